// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and its ALU decoder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mul_mips_alu_decoder.sv
// ALU control decoder: main-FSM alu_op plus R-type funct -> ALU operation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module mul_mips_alu_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int alu_op_width   = 2,
   parameter int function_width = 6,
   parameter int alu_con_width  = 3
) (
   input  logic [alu_op_width-1:0]   alu_op,
   input  logic [function_width-1:0] funct,
   output logic [alu_con_width-1:0]  alu_control
);

   // Unknown funct codes fall back to add so the datapath never sees an undefined op.
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_control = ALU_ADD;
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_SLT:  alu_control = ALU_SLT;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mul_mips_main_ctrl.sv
// Multicycle MIPS main control FSM (Moore) driving the shared datapath selects/enables.
// Latency: outputs combinational from state; lw 5, sw/R/addi 4, beq/j 3, illegal 2 cycles.
// Backpressure: none; one instruction sequenced at a time, reset forces all outputs low.
module mul_mips_main_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int opcode_width   = 6,
   parameter int function_width = 6,
   parameter int alu_op_width   = 2,
   parameter int alu_con_width  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [opcode_width-1:0]   opcode,
   input  logic [function_width-1:0] funct,
   input  logic                      zero,
   output logic                      iord,
   output logic                      mem_write,
   output logic                      ir_write,
   output logic                      reg_dst,
   output logic                      mem_to_reg,
   output logic                      reg_write,
   output logic                      alu_src_a,
   output logic [1:0]                alu_src_b,
   output logic [1:0]                pc_src,
   output logic                      pc_en,
   output logic [alu_con_width-1:0]  alu_control,
   output logic                      illegal_op,
   output logic [3:0]                state_dbg
);

   state_t                    state, state_nxt;
   logic                      s_iord, s_mem_write, s_ir_write, s_reg_dst;
   logic                      s_mem_to_reg, s_reg_write, s_alu_src_a;
   logic [1:0]                s_alu_src_b, s_pc_src;
   logic                      pc_write, branch, s_illegal;
   logic [alu_op_width-1:0]   alu_op;
   logic [alu_con_width-1:0]  dec_alu_control;

   // State register; reset always restarts at instruction fetch.
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nxt;
   end

   // Next-state and per-state control decode; anything not set stays 0.
   always_comb begin
      state_nxt    = S_FETCH;
      s_iord       = 1'b0;
      s_mem_write  = 1'b0;
      s_ir_write   = 1'b0;
      s_reg_dst    = 1'b0;
      s_mem_to_reg = 1'b0;
      s_reg_write  = 1'b0;
      s_alu_src_a  = 1'b0;
      s_alu_src_b  = 2'b00;
      s_pc_src     = 2'b00;
      pc_write     = 1'b0;
      branch       = 1'b0;
      s_illegal    = 1'b0;
      alu_op       = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            s_alu_src_b = 2'b01;
            s_ir_write  = 1'b1;
            pc_write    = 1'b1;
            state_nxt   = S_DECODE;
         end
         S_DECODE: begin
            s_alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_EXECUTE;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_J:         state_nxt = S_JUMP;
               default: begin
                  s_illegal = 1'b1;
                  state_nxt = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            s_alu_src_a = 1'b1;
            s_alu_src_b = 2'b10;
            state_nxt   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            s_iord    = 1'b1;
            state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            s_mem_to_reg = 1'b1;
            s_reg_write  = 1'b1;
         end
         S_MEMWR: begin
            s_iord      = 1'b1;
            s_mem_write = 1'b1;
         end
         S_EXECUTE: begin
            s_alu_src_a = 1'b1;
            alu_op      = ALUOP_FUNCT;
            state_nxt   = S_ALUWB;
         end
         S_ALUWB: begin
            s_reg_dst   = 1'b1;
            s_reg_write = 1'b1;
         end
         S_BRANCH: begin
            s_alu_src_a = 1'b1;
            alu_op      = ALUOP_SUB;
            s_pc_src    = 2'b01;
            branch      = 1'b1;
         end
         S_ADDIEX: begin
            s_alu_src_a = 1'b1;
            s_alu_src_b = 2'b10;
            state_nxt   = S_ADDIWB;
         end
         S_ADDIWB: begin
            s_reg_write = 1'b1;
         end
         S_JUMP: begin
            s_pc_src = 2'b10;
            pc_write = 1'b1;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   mul_mips_alu_decoder #(
      .alu_op_width   (alu_op_width),
      .function_width (function_width),
      .alu_con_width  (alu_con_width)
   ) u_alu_decoder (
      .alu_op      (alu_op),
      .funct       (funct),
      .alu_control (dec_alu_control)
   );

   // Output stage: reset holds every output low so no write can leak out mid-abort.
   always_comb begin
      iord        = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_src      = 2'b00;
      pc_en       = 1'b0;
      alu_control = '0;
      illegal_op  = 1'b0;
      state_dbg   = 4'd0;
      if (!rst) begin
         iord        = s_iord;
         mem_write   = s_mem_write;
         ir_write    = s_ir_write;
         reg_dst     = s_reg_dst;
         mem_to_reg  = s_mem_to_reg;
         reg_write   = s_reg_write;
         alu_src_a   = s_alu_src_a;
         alu_src_b   = s_alu_src_b;
         pc_src      = s_pc_src;
         pc_en       = pc_write | (branch & zero);
         alu_control = dec_alu_control;
         illegal_op  = s_illegal;
         state_dbg   = state;
      end
   end

endmodule

// File: tb/tb_mul_mips_main_ctrl.sv
module tb_mul_mips_main_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       zero;
   logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic       pc_en, illegal_op;
   logic [2:0] alu_control;
   logic [3:0] state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_mips_main_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en),
      .alu_control(alu_control), .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   typedef struct packed {
      logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [1:0] alu_src_b, pc_src;
      logic       pc_en;
      logic [2:0] alu_control;
      logic       illegal_op;
      logic [3:0] state_dbg;
   } ctrl_t;

   typedef struct {
      logic [31:0] instr;
      logic        zero;
      int          latency;
      string       name;
   } vec_t;

   function automatic ctrl_t sample();
      ctrl_t c;
      c = '{iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
            alu_src_b, pc_src, pc_en, alu_control, illegal_op, state_dbg};
      return c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference ALU control: table of operations the ALU must perform.
   function automatic logic [2:0] alu_ref(input int aluop, input logic [5:0] fn);
      if (aluop == 1) return 3'b110;
      if (aluop == 2) begin
         if (fn == 6'h20) return 3'b010;
         if (fn == 6'h22) return 3'b110;
         if (fn == 6'h24) return 3'b000;
         if (fn == 6'h25) return 3'b001;
         if (fn == 6'h2A) return 3'b111;
      end
      return 3'b010;
   endfunction

   function automatic bit legal(input logic [5:0] op);
      return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
   endfunction

   // Instruction class -> list of visited steps.
   task automatic get_path(input logic [5:0] op, output int n, output int st[5]);
      st = '{0, 1, 0, 0, 0};
      case (op)
         6'h23:   begin n = 5; st[2] = 2; st[3] = 3; st[4] = 4; end
         6'h2B:   begin n = 4; st[2] = 2; st[3] = 5; end
         6'h00:   begin n = 4; st[2] = 6; st[3] = 7; end
         6'h08:   begin n = 4; st[2] = 9; st[3] = 10; end
         6'h04:   begin n = 3; st[2] = 8; end
         6'h02:   begin n = 3; st[2] = 11; end
         default: n = 2;
      endcase
   endtask

   // Expected control word for a given step, straight from the per-step signal list.
   function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] op, input logic [5:0] fn,
                                      input logic z);
      ctrl_t e = '0;
      int aluop = 0;
      e.state_dbg = 4'(st);
      case (st)
         0:  begin e.alu_src_b = 2'b01; e.ir_write = 1; e.pc_en = 1; end
         1:  begin e.alu_src_b = 2'b11; e.illegal_op = !legal(op); end
         2, 9: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         3:  e.iord = 1;
         4:  begin e.mem_to_reg = 1; e.reg_write = 1; end
         5:  begin e.iord = 1; e.mem_write = 1; end
         6:  begin e.alu_src_a = 1; aluop = 2; end
         7:  begin e.reg_dst = 1; e.reg_write = 1; end
         8:  begin e.alu_src_a = 1; aluop = 1; e.pc_src = 2'b01; e.pc_en = z; end
         10: e.reg_write = 1;
         11: begin e.pc_src = 2'b10; e.pc_en = 1; end
         default: ;
      endcase
      e.alu_control = alu_ref(aluop, fn);
      return e;
   endfunction

   // Called just after a rising edge with the DUT in FETCH; returns at the same point.
   // zmode: 0/1 fixed zero, 2 random per cycle.
   task automatic run_instr(input logic [31:0] instr, input int zmode, input string tag,
                            output int lat, output int n_ill, output int n_wr);
      int n;
      int st[5];
      ctrl_t act, exp;
      opcode = instr[31:26];
      funct  = instr[5:0];
      get_path(opcode, n, st);
      lat = 0; n_ill = 0; n_wr = 0;
      for (int i = 0; i < n; i++) begin
         zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
         @(negedge clk);
         act = sample();
         exp = exp_ctrl(st[i], opcode, funct, zero);
         check($sformatf("%s step%0d ctrl", tag, i), 32'(act), 32'(exp));
         if (i == 0 || state_dbg != 4'd0) lat++;
         if (illegal_op) n_ill++;
         if (reg_write || mem_write) n_wr++;
         @(posedge clk);
         #1;
      end
      check({tag, " back_to_fetch"}, 32'(state_dbg), 32'd0);
   endtask

   vec_t vecs[13];

   initial begin
      int lat, n_ill, n_wr;
      logic [5:0] op, fn;
      logic [5:0] ops[7];
      logic [5:0] fns[6];

      vecs[0]  = '{32'h20020005, 1'b0, 4, "addi"};
      vecs[1]  = '{32'h00e22025, 1'b0, 4, "or"};
      vecs[2]  = '{32'h0064202a, 1'b0, 4, "slt"};
      vecs[3]  = '{32'h00851020, 1'b0, 4, "add"};
      vecs[4]  = '{32'h00851022, 1'b0, 4, "sub"};
      vecs[5]  = '{32'h00851024, 1'b0, 4, "and"};
      vecs[6]  = '{32'h0085103f, 1'b0, 4, "rtype_badfunct"};
      vecs[7]  = '{32'h10a7000a, 1'b1, 3, "beq_taken"};
      vecs[8]  = '{32'h10a7000a, 1'b0, 3, "beq_not_taken"};
      vecs[9]  = '{32'h8c020050, 1'b0, 5, "lw"};
      vecs[10] = '{32'hac670044, 1'b0, 4, "sw"};
      vecs[11] = '{32'hfc000000, 1'b0, 2, "illegal"};
      vecs[12] = '{32'h08000011, 1'b0, 3, "j"};

      // Reset state: every output low, even before the first edge.
      rst = 1'b1; opcode = 6'h0; funct = 6'h0; zero = 1'b1;
      @(negedge clk);
      check("reset_outputs", 32'(sample()), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Table-driven instruction sequences.
      foreach (vecs[k]) begin
         run_instr(vecs[k].instr, int'(vecs[k].zero), vecs[k].name, lat, n_ill, n_wr);
         check({vecs[k].name, " latency"}, 32'(lat), 32'(vecs[k].latency));
         if (vecs[k].name == "illegal") begin
            check("illegal pulse_count", 32'(n_ill), 32'd1);
            check("illegal no_writes", 32'(n_wr), 32'd0);
         end else begin
            check({vecs[k].name, " no_illegal"}, 32'(n_ill), 32'd0);
         end
      end

      // Reset in the middle of a store: must abort with mem_write held low.
      opcode = 6'h2B; funct = 6'h04; zero = 1'b0;
      @(posedge clk); #1;   // DECODE
      @(posedge clk); #1;   // MEMADR
      @(posedge clk); #1;   // MEMWR
      @(negedge clk);
      check("midwr state", 32'(state_dbg), 32'd5);
      check("midwr mem_write_before", 32'(mem_write), 32'd1);
      rst = 1'b1;
      #1;
      check("midwr outputs_in_reset", 32'(sample()), 32'd0);
      for (int e = 0; e < 2; e++) begin
         @(posedge clk); #1;
         check($sformatf("midwr mem_write_reset%0d", e), 32'(mem_write), 32'd0);
         check($sformatf("midwr outputs_reset%0d", e), 32'(sample()), 32'd0);
      end
      rst = 1'b0;
      #1;
      check("post_reset state", 32'(state_dbg), 32'd0);
      check("post_reset ir_write", 32'(ir_write), 32'd1);
      check("post_reset pc_en", 32'(pc_en), 32'd1);

      // Randomized instruction mix against the model, with random zero each cycle.
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
      for (int r = 0; r < 200; r++) begin
         op = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         fn = fns[$urandom_range(0, 5)];
         if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
         run_instr({op, 20'($urandom), fn}, 2, $sformatf("rand%0d", r), lat, n_ill, n_wr);
         check($sformatf("rand%0d illegal_count", r), 32'(n_ill), legal(op) ? 32'd0 : 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
